// File: rtl/fpga_reg_pkg.sv
// Shared constants for the PL user-register block: register offsets, AXI
// response codes, CTRL bit positions and the handshake state encodings.
package fpga_reg_pkg;

  localparam logic [7:0] UREG_FIRMWARE_DATE = 8'h00;
  localparam logic [7:0] UREG_FIRMWARE_TIME = 8'h04;
  localparam logic [7:0] UREG_TEST0         = 8'h08;
  localparam logic [7:0] UREG_TEST1         = 8'h0C;
  localparam logic [7:0] UREG_CTRL          = 8'h10;

  localparam logic [5:0] IDX_FIRMWARE_DATE = UREG_FIRMWARE_DATE[7:2];
  localparam logic [5:0] IDX_FIRMWARE_TIME = UREG_FIRMWARE_TIME[7:2];
  localparam logic [5:0] IDX_TEST0         = UREG_TEST0[7:2];
  localparam logic [5:0] IDX_TEST1         = UREG_TEST1[7:2];
  localparam logic [5:0] IDX_CTRL          = UREG_CTRL[7:2];

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  localparam int CTRL_NPWR_DWN  = 0;
  localparam int CTRL_MII_RST_N = 1;
  localparam int CTRL_LED_FORCE = 2;
  localparam int CTRL_LED_VAL   = 3;
  localparam logic [3:0] CTRL_RESET = 4'b0001;

  typedef enum logic [1:0] {W_IDLE = 2'b00, W_ACK = 2'b01, W_RESP = 2'b10} wr_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'b00, R_ACK = 2'b01, R_DATA = 2'b10} rd_state_e;

  // The map is contiguous from offset 0, so one bound covers every register.
  function automatic logic ureg_mapped(input logic [5:0] idx);
    return idx <= IDX_CTRL;
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/main_ureg_if.sv
// AXI4-Lite bundle between the PS7 GP0 master and the user-register slave.
interface main_ureg_if;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/main_ureg_axil_slave_if.sv
// AXI4-Lite slave handshake: turns bus transactions into one-cycle register
// write/read strobes and returns registered responses.
module axil_slave_if
  import fpga_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  main_ureg_if.slave  axi,
  output logic        wr_en_o,
  output logic [5:0]  wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_strb_o,
  output logic        rd_en_o,
  output logic [5:0]  rd_addr_o,
  input  logic [31:0] rd_data_i
);

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        unused_addr_lsbs;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      bresp_q    <= AXI_OKAY;
      rresp_q    <= AXI_OKAY;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  // Address and data are only taken together; a lone channel simply waits.
  always_comb begin
    wr_state_d = wr_state_q;
    bresp_d    = bresp_q;
    unique case (wr_state_q)
      W_IDLE: if (axi.awvalid && axi.wvalid) wr_state_d = W_ACK;
      W_ACK: begin
        wr_state_d = W_RESP;
        bresp_d    = ureg_mapped(wr_addr_o) ? AXI_OKAY : AXI_SLVERR;
      end
      W_RESP: if (axi.bready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      R_IDLE: if (axi.arvalid) rd_state_d = R_ACK;
      R_ACK: begin
        rd_state_d = R_DATA;
        rdata_d    = rd_data_i;
        rresp_d    = ureg_mapped(rd_addr_o) ? AXI_OKAY : AXI_SLVERR;
      end
      R_DATA: if (axi.rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign axi.awready = (wr_state_q == W_ACK);
  assign axi.wready  = (wr_state_q == W_ACK);
  assign axi.bvalid  = (wr_state_q == W_RESP);
  assign axi.bresp   = bresp_q;
  assign axi.arready = (rd_state_q == R_ACK);
  assign axi.rvalid  = (rd_state_q == R_DATA);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  assign wr_en_o   = (wr_state_q == W_ACK);
  assign wr_addr_o = axi.awaddr[7:2];
  assign wr_data_o = axi.wdata;
  assign wr_strb_o = axi.wstrb;
  assign rd_en_o   = (rd_state_q == R_ACK);
  assign rd_addr_o = axi.araddr[7:2];

  assign unused_addr_lsbs = ^{axi.awaddr[1:0], axi.araddr[1:0]};

endmodule

// File: rtl/main_ureg.sv
// PL user registers: firmware date/time ID, two scratch registers and the
// board-pin control register with a heartbeat-driven user LED.
module main_ureg
  import fpga_reg_pkg::*;
#(
  parameter bit          SIM     = 1'b0,
  parameter logic [31:0] FW_DATE = 32'h0000_0000,
  parameter logic [31:0] FW_TIME = 32'h0000_0000
) (
  input  logic       ACLK,
  input  logic       ARESET,
  main_ureg_if.slave s_axi,
  output logic       usr_led,
  output logic       eth_phy_npwr_dwn,
  output logic       mii_rst_n
);

  localparam int HB_W = SIM ? 4 : 24;

  logic            wr_en;
  logic [5:0]      wr_addr;
  logic [31:0]     wr_data;
  logic [3:0]      wr_strb;
  logic            rd_en;
  logic [5:0]      rd_addr;
  logic [31:0]     rd_data;

  logic [31:0]     test0_q, test0_d;
  logic [31:0]     test1_q, test1_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [HB_W-1:0] hb_q, hb_d;
  logic            usr_led_q, usr_led_d;

  axil_slave_if u_axil (
    .clk       (ACLK),
    .rst       (ARESET),
    .axi       (s_axi),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data)
  );

  // Writes to the read-only ID words and to unmapped offsets fall through untouched.
  always_comb begin
    test0_d = test0_q;
    test1_d = test1_q;
    ctrl_d  = ctrl_q;
    if (wr_en) begin
      case (wr_addr)
        IDX_TEST0: test0_d = apply_wstrb(test0_q, wr_data, wr_strb);
        IDX_TEST1: test1_d = apply_wstrb(test1_q, wr_data, wr_strb);
        IDX_CTRL:  if (wr_strb[0]) ctrl_d = wr_data[3:0];
        default:   ;
      endcase
    end
    hb_d      = hb_q + 1'b1;
    usr_led_d = ctrl_q[CTRL_LED_FORCE] ? ctrl_q[CTRL_LED_VAL] : hb_q[HB_W-1];
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (rd_addr)
        IDX_FIRMWARE_DATE: rd_data = FW_DATE;
        IDX_FIRMWARE_TIME: rd_data = FW_TIME;
        IDX_TEST0:         rd_data = test0_q;
        IDX_TEST1:         rd_data = test1_q;
        IDX_CTRL:          rd_data = {28'd0, ctrl_q};
        default:           rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      test0_q   <= '0;
      test1_q   <= '0;
      ctrl_q    <= CTRL_RESET;
      hb_q      <= '0;
      usr_led_q <= 1'b0;
    end else begin
      test0_q   <= test0_d;
      test1_q   <= test1_d;
      ctrl_q    <= ctrl_d;
      hb_q      <= hb_d;
      usr_led_q <= usr_led_d;
    end
  end

  assign usr_led          = usr_led_q;
  assign eth_phy_npwr_dwn = ctrl_q[CTRL_NPWR_DWN];
  assign mii_rst_n        = ctrl_q[CTRL_MII_RST_N];

endmodule

// File: tb/tb_main_ureg.sv
// Directed bench for main_ureg: a transaction-level register model tracks the
// bus and pins, and a compare process checks the DUT against it every cycle.
module tb_main_ureg;
  import fpga_reg_pkg::*;

  localparam logic [31:0] FW_DATE = 32'h2019_0315;
  localparam logic [31:0] FW_TIME = 32'h0012_3456;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic usrLed, ethNpwrDwn, miiRstN;

  main_ureg_if axi ();

  main_ureg #(.SIM(1'b1), .FW_DATE(FW_DATE), .FW_TIME(FW_TIME)) dut (
    .ACLK             (clk),
    .ARESET           (rst),
    .s_axi            (axi),
    .usr_led          (usrLed),
    .eth_phy_npwr_dwn (ethNpwrDwn),
    .mii_rst_n        (miiRstN)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  task automatic ruleCheck(input string name, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got violation, required rule to hold", name);
    end
  endtask

  // Register model: updated only by completed AXI handshakes seen at a clock edge.
  typedef struct packed {logic [31:0] data; logic [1:0] resp;} rsp_t;
  logic [31:0] mTest0, mTest1;
  logic [3:0]  mCtrl;
  int          mEdges;
  logic        expLed;
  rsp_t        rdQ[$];
  logic [1:0]  bQ[$];

  function automatic bit modelMapped(input logic [7:0] a);
    return (a & 8'hFC) <= 8'h10;
  endfunction

  function automatic logic [31:0] modelRead(input logic [7:0] a);
    case (a & 8'hFC)
      8'h00:   return FW_DATE;
      8'h04:   return FW_TIME;
      8'h08:   return mTest0;
      8'h0C:   return mTest1;
      8'h10:   return {28'd0, mCtrl};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mTest0 = '0; mTest1 = '0; mCtrl = 4'h1; mEdges = 0; expLed = 1'b0;
      rdQ.delete(); bQ.delete();
    end else begin
      expLed = mCtrl[2] ? mCtrl[3] : ((mEdges % 16) >= 8);
      mEdges++;
      if (axi.rvalid && axi.rready && rdQ.size() > 0) void'(rdQ.pop_front());
      if (axi.bvalid && axi.bready && bQ.size() > 0) void'(bQ.pop_front());
      if (axi.arvalid && axi.arready)
        rdQ.push_back({modelRead(axi.araddr), modelMapped(axi.araddr) ? AXI_OKAY : AXI_SLVERR});
      if (axi.awvalid && axi.wvalid && axi.awready && axi.wready) begin
        bQ.push_back(modelMapped(axi.awaddr) ? AXI_OKAY : AXI_SLVERR);
        case (axi.awaddr & 8'hFC)
          8'h08:   mTest0 = mergeBytes(mTest0, axi.wdata, axi.wstrb);
          8'h0C:   mTest1 = mergeBytes(mTest1, axi.wdata, axi.wstrb);
          8'h10:   if (axi.wstrb[0]) mCtrl = axi.wdata[3:0];
          default: ;
        endcase
      end
    end
  end

  // Compare process: pins and any valid response against the model, plus handshake rules.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("usr_led", 32'(usrLed), 32'(expLed));
      checkOutput("eth_phy_npwr_dwn", 32'(ethNpwrDwn), 32'(mCtrl[0]));
      checkOutput("mii_rst_n", 32'(miiRstN), 32'(mCtrl[1]));
      ruleCheck("awready_wready_together", axi.awready === axi.wready);
      ruleCheck("awready_needs_both_valid", !axi.awready || (axi.awvalid && axi.wvalid));
      ruleCheck("no_accept_while_bvalid", !(axi.awready && axi.bvalid));
      ruleCheck("no_accept_while_rvalid", !(axi.arready && axi.rvalid));
      if (axi.rvalid) begin
        ruleCheck("rvalid_expected", rdQ.size() > 0);
        if (rdQ.size() > 0) begin
          checkOutput("rdata_vs_model", axi.rdata, rdQ[0].data);
          checkOutput("rresp_vs_model", 32'(axi.rresp), 32'(rdQ[0].resp));
        end
      end
      if (axi.bvalid) begin
        ruleCheck("bvalid_expected", bQ.size() > 0);
        if (bQ.size() > 0) checkOutput("bresp_vs_model", 32'(axi.bresp), 32'(bQ[0]));
      end
    end
  end

  // One complete write or read with full-ready master; checks handshake latency.
  task automatic applyStimulus(input bit doWrite, input logic [7:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [31:0] rdata, output logic [1:0] resp);
    int n;
    rdata = '0;
    resp  = '0;
    @(posedge clk); #1;
    if (doWrite) begin
      axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!axi.awready && n < 16);
      checkOutput("awready_latency", n, 1);
      @(posedge clk); #1;
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      checkOutput("bvalid_after_handshake", 32'(axi.bvalid), 32'd1);
      resp = axi.bresp;
      @(posedge clk); #1;
      checkOutput("bvalid_cleared", 32'(axi.bvalid), 32'd0);
    end else begin
      axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!axi.arready && n < 16);
      @(posedge clk); #1;
      axi.arvalid = 1'b0;
      checkOutput("arvalid_to_rvalid_latency", n + 1, 2);
      checkOutput("rvalid_after_handshake", 32'(axi.rvalid), 32'd1);
      rdata = axi.rdata;
      resp  = axi.rresp;
      @(posedge clk); #1;
      checkOutput("rvalid_cleared", 32'(axi.rvalid), 32'd0);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_awready", 32'(axi.awready), 32'd0);
    checkOutput("rst_wready", 32'(axi.wready), 32'd0);
    checkOutput("rst_arready", 32'(axi.arready), 32'd0);
    checkOutput("rst_bvalid", 32'(axi.bvalid), 32'd0);
    checkOutput("rst_rvalid", 32'(axi.rvalid), 32'd0);
    checkOutput("rst_rdata", axi.rdata, 32'd0);
    checkOutput("rst_resps", 32'({axi.bresp, axi.rresp}), 32'd0);
    checkOutput("rst_usr_led", 32'(usrLed), 32'd0);
    checkOutput("rst_eth_phy_npwr_dwn", 32'(ethNpwrDwn), 32'd1);
    checkOutput("rst_mii_rst_n", 32'(miiRstN), 32'd0);
  endtask

  typedef struct packed {
    bit wr; logic [7:0] addr; logic [31:0] data; logic [3:0] strb;
    logic [31:0] expData; logic [1:0] expResp;
  } vec_t;
  vec_t vecs [0:13];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        prev;
    int          n;

    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h2019_0315, AXI_OKAY};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h0012_3456, AXI_OKAY};
    vecs[2]  = '{1'b1, 8'h08, 32'hDEADBEAF,  4'hF, 32'h0,         AXI_OKAY};
    vecs[3]  = '{1'b1, 8'h0C, 32'h00A5A5A5,  4'hF, 32'h0,         AXI_OKAY};
    vecs[4]  = '{1'b0, 8'h08, 32'h0,         4'h0, 32'hDEADBEAF,  AXI_OKAY};
    vecs[5]  = '{1'b0, 8'h0C, 32'h0,         4'h0, 32'h00A5A5A5,  AXI_OKAY};
    vecs[6]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 4'h2, 32'h0,         AXI_OKAY};
    vecs[7]  = '{1'b0, 8'h08, 32'h0,         4'h0, 32'hDEADFFAF,  AXI_OKAY};
    vecs[8]  = '{1'b0, 8'h40, 32'h0,         4'h0, 32'h0,         AXI_SLVERR};
    vecs[9]  = '{1'b1, 8'h00, 32'h1,         4'hF, 32'h0,         AXI_OKAY};
    vecs[10] = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h2019_0315, AXI_OKAY};
    vecs[11] = '{1'b1, 8'h44, 32'h1234_5678, 4'hF, 32'h0,         AXI_SLVERR};
    vecs[12] = '{1'b0, 8'h0B, 32'h0,         4'h0, 32'hDEADFFAF,  AXI_OKAY};
    vecs[13] = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h0000_0001, AXI_OKAY};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkResetState();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, rd, rs);
      if (!vecs[i].wr) checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expData);
      checkOutput($sformatf("vec%0d_resp", i), 32'(rs), 32'(vecs[i].expResp));
    end

    // Address leads data by three cycles, then the response is back-pressured.
    @(posedge clk); #1;
    axi.awaddr = 8'h0C; axi.awvalid = 1'b1; axi.wvalid = 1'b0; axi.bready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("aw_only_not_accepted", 32'(axi.awready), 32'd0);
    end
    axi.wdata = 32'hCAFE_0001; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall_awready", 32'(axi.awready), 32'd1);
    @(posedge clk); #1;
    axi.awaddr = 8'h08; axi.wdata = 32'h1122_3344;
    repeat (5) begin
      checkOutput("stall_bvalid_held", 32'(axi.bvalid), 32'd1);
      checkOutput("stall_no_second_accept", 32'(axi.awready), 32'd0);
      @(posedge clk); #1;
    end
    axi.bready = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall_bvalid_released", 32'(axi.bvalid), 32'd0);
    @(posedge clk); #1;
    checkOutput("second_write_accepted", 32'(axi.awready), 32'd1);
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 8'h0C, 32'h0, 4'h0, rd, rs);
    checkOutput("stall_first_data", rd, 32'hCAFE_0001);
    applyStimulus(1'b0, 8'h08, 32'h0, 4'h0, rd, rs);
    checkOutput("stall_second_data", rd, 32'h1122_3344);

    // Heartbeat half-period with the LED not forced.
    applyStimulus(1'b1, 8'h10, 32'h0, 4'hF, rd, rs);
    prev = usrLed; n = 0;
    do begin @(posedge clk); #1; n++; end while (usrLed === prev && n < 20);
    prev = usrLed; n = 0;
    do begin @(posedge clk); #1; n++; end while (usrLed === prev && n < 20);
    checkOutput("heartbeat_half_period", n, 8);

    applyStimulus(1'b1, 8'h10, 32'h0000_000F, 4'hF, rd, rs);
    checkOutput("ctrl_f_usr_led", 32'(usrLed), 32'd1);
    checkOutput("ctrl_f_npwr_dwn", 32'(ethNpwrDwn), 32'd1);
    checkOutput("ctrl_f_mii_rst_n", 32'(miiRstN), 32'd1);

    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkResetState();
    applyStimulus(1'b0, 8'h10, 32'h0, 4'h0, rd, rs);
    checkOutput("ctrl_after_reset", rd, 32'h0000_0001);

    // Reset while a read is in flight: no response may follow.
    @(posedge clk); #1;
    axi.araddr = 8'h00; axi.arvalid = 1'b1; axi.rready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; axi.arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("aborted_read_no_rvalid", 32'(axi.rvalid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
